// File: rtl/conv_weight_sched_pkg.sv
// Shared types and defaults for the conv weight load sequencer.
// State encoding matches the register values visible in debug dumps.
package conv_weight_sched_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_PEND  = 3'd4
    } state_t;

    // Frames may flow whenever a complete weight set is resident.
    function automatic logic frames_allowed(input state_t s);
        return (s == ST_READY) || (s == ST_RUN) || (s == ST_PEND);
    endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// Weight write address / remaining-count pair: load, step, last flag.
// Latency: addr and last reflect the registered pair; no backpressure of its own.
module weight_addr_gen
    import conv_weight_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH-1:0] load_count,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            addr_q <= load_base;
            rem_q  <= load_count;
        end else if (step) begin
            // Address wraps silently at the top of the address space.
            addr_q <= addr_q + ADDR_WIDTH'(1);
            rem_q  <= rem_q - ADDR_WIDTH'(1);
        end
    end

    assign addr = addr_q;
    assign last = (rem_q == ADDR_WIDTH'(1));

endmodule

// File: rtl/conv_weight_sched.sv
// Streams weights into one conv layer and gates its pixel input until weights are complete.
// Latency 1 from stream handshake to weight write; reloads wait for frame_done of the running frame.
module conv_weight_sched
    import conv_weight_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_num_words,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] weight_wr_data,
    output logic [ADDR_WIDTH-1:0] weight_wr_addr,
    output logic                  weight_wr_en,
    input  logic                  up_valid,
    output logic                  conv_i_valid,
    input  logic                  frame_done,
    output logic                  frame_en,
    output logic                  busy,
    output logic                  load_done,
    output logic                  err
);

    state_t                state_q, state_d;
    logic                  s_ready_q, frame_en_q, busy_q;
    logic                  wr_en_q, load_done_q, err_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] pend_base_q, pend_num_q;

    logic                  accept, cfg_ok;
    logic                  load_cfg, load_pend, latch_pend, err_d;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;

    assign accept       = s_valid & s_ready_q;
    assign cfg_ok       = (cfg_num_words != '0);
    assign conv_i_valid = up_valid & frame_en_q;

    always_comb begin
        state_d    = state_q;
        load_cfg   = 1'b0;
        load_pend  = 1'b0;
        latch_pend = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_ok) begin
                        state_d  = ST_LOAD;
                        load_cfg = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                err_d = cfg_start;
                if (accept && gen_last) state_d = ST_READY;
            end
            ST_READY: begin
                err_d = cfg_start & ~cfg_ok;
                // A pixel accepted this cycle has started a frame, so a
                // simultaneous reload must wait for that frame to end.
                if (conv_i_valid) begin
                    if (cfg_start && cfg_ok) begin
                        state_d    = ST_PEND;
                        latch_pend = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (cfg_start && cfg_ok) begin
                    state_d  = ST_LOAD;
                    load_cfg = 1'b1;
                end
            end
            ST_RUN: begin
                err_d = cfg_start & ~cfg_ok;
                if (frame_done) begin
                    if (cfg_start && cfg_ok) begin
                        state_d  = ST_LOAD;
                        load_cfg = 1'b1;
                    end else begin
                        state_d = ST_READY;
                    end
                end else if (cfg_start && cfg_ok) begin
                    state_d    = ST_PEND;
                    latch_pend = 1'b1;
                end
            end
            ST_PEND: begin
                err_d = cfg_start;
                if (frame_done) begin
                    state_d   = ST_LOAD;
                    load_pend = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    weight_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_cfg | load_pend),
        .load_base  (load_pend ? pend_base_q : cfg_base_addr),
        .load_count (load_pend ? pend_num_q  : cfg_num_words),
        .step       (accept),
        .addr       (gen_addr),
        .last       (gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_ready_q   <= 1'b0;
            frame_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            pend_base_q <= '0;
            pend_num_q  <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= (state_d == ST_LOAD);
            frame_en_q  <= frames_allowed(state_d);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_PEND);
            wr_en_q     <= accept;
            load_done_q <= accept & gen_last;
            err_q       <= err_d;
            if (accept) begin
                wr_data_q <= s_data;
                wr_addr_q <= gen_addr;
            end
            if (latch_pend) begin
                pend_base_q <= cfg_base_addr;
                pend_num_q  <= cfg_num_words;
            end
        end
    end

    assign s_ready        = s_ready_q;
    assign frame_en       = frame_en_q;
    assign busy           = busy_q;
    assign weight_wr_en   = wr_en_q;
    assign weight_wr_data = wr_data_q;
    assign weight_wr_addr = wr_addr_q;
    assign load_done      = load_done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_conv_weight_sched.sv
// Scoreboard bench for conv_weight_sched: expected writes are queued at each
// stream handshake and popped by an independent write monitor.
module tb_conv_weight_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [31:0] cfg_num_words = '0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] weight_wr_data;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en;
    logic        up_valid = 1'b0;
    logic        conv_i_valid;
    logic        frame_done = 1'b0;
    logic        frame_en;
    logic        busy;
    logic        load_done;
    logic        err;

    conv_weight_sched dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
        .weight_wr_en(weight_wr_en), .up_valid(up_valid),
        .conv_i_valid(conv_i_valid), .frame_done(frame_done),
        .frame_en(frame_en), .busy(busy), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          exp_errs = 0;
    logic [31:0] ld_base;
    int          ld_num;
    int          ld_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every weight write must match the oldest expected one.
    always @(negedge clk) begin
        if (weight_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(weight_wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(weight_wr_addr), 64'(mon_e.addr));
                chk("wr_data", 64'(weight_wr_data), 64'(mon_e.data));
                chk("load_done_on_write", 64'(load_done), 64'(mon_e.last));
            end
        end else if (load_done === 1'b1) begin
            chk("load_done_without_write", 64'(load_done), 64'd0);
        end
        if (err === 1'b1) err_seen++;
    end

    // All tasks start and end at posedge+1.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_cfg(input logic [31:0] base, input logic [31:0] num, input logic fd);
        cfg_start     = 1'b1;
        cfg_base_addr = base;
        cfg_num_words = num;
        frame_done    = fd;
        step(1);
        cfg_start  = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        step(1);
        frame_done = 1'b0;
    endtask

    task automatic begin_load(input logic [31:0] base, input int num);
        ld_base = base;
        ld_num  = num;
        ld_idx  = 0;
    endtask

    // mode 0: valid held, 1: valid toggles 1,0,..., 2: random valid and data.
    task automatic stream(input int n, input int mode, input logic [15:0] dbase);
        int   sent = 0;
        int   cyc  = 0;
        logic hs;
        wr_t  e;
        while (sent < n && cyc < 200) begin
            s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            s_data  = (mode == 2) ? 16'($urandom) : dbase + 16'(sent);
            sample();
            hs = s_valid & s_ready;
            @(posedge clk);
            if (hs) begin
                e.addr = ld_base + 32'(ld_idx);
                e.data = s_data;
                e.last = (ld_idx == ld_num - 1);
                exp_q.push_back(e);
                ld_idx++;
                sent++;
            end
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        chk("stream_words_accepted", 64'(sent), 64'(n));
    endtask

    initial begin
        logic [31:0] b;
        int          n;

        // Reset state, with upstream pixels offered to confirm the gate.
        up_valid = 1'b1;
        step(3);
        sample();
        chk("rst_s_ready", 64'(s_ready), 0);
        chk("rst_wr_en", 64'(weight_wr_en), 0);
        chk("rst_frame_en", 64'(frame_en), 0);
        chk("rst_conv_i_valid", 64'(conv_i_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err), 0);
        step(1);
        rst_n    = 1'b1;
        up_valid = 1'b0;
        step(1);

        // 1: contiguous load, valid held high.
        pulse_cfg(32'd17176, 32'd4, 1'b0);
        begin_load(32'd17176, 4);
        sample();
        chk("t1_busy_in_load", 64'(busy), 1);
        chk("t1_s_ready_in_load", 64'(s_ready), 1);
        step(1);
        stream(4, 0, 16'hA001);
        sample();
        chk("t1_load_done", 64'(load_done), 1);
        chk("t1_frame_en", 64'(frame_en), 1);
        chk("t1_s_ready_drop", 64'(s_ready), 0);
        chk("t1_busy_clear", 64'(busy), 0);
        step(1);

        // 2: same load with toggling valid.
        pulse_cfg(32'd17176, 32'd4, 1'b0);
        begin_load(32'd17176, 4);
        stream(4, 1, 16'hB001);
        sample();
        chk("t2_frame_en", 64'(frame_en), 1);
        step(1);

        // 3: reload during a frame is deferred to frame_done.
        up_valid = 1'b1;
        sample();
        chk("t3_conv_i_valid", 64'(conv_i_valid), 1);
        step(1);
        up_valid = 1'b0;
        pulse_cfg(32'd100, 32'd2, 1'b0);
        sample();
        chk("t3_pend_frame_en", 64'(frame_en), 1);
        chk("t3_pend_busy", 64'(busy), 1);
        chk("t3_pend_s_ready", 64'(s_ready), 0);
        step(1);
        pulse_cfg(32'd777, 32'd9, 1'b0);
        exp_errs++;
        sample();
        chk("t3_pend_err", 64'(err), 1);
        step(3);
        pulse_fd();
        begin_load(32'd100, 2);
        sample();
        chk("t3_frame_en_off", 64'(frame_en), 0);
        chk("t3_load_s_ready", 64'(s_ready), 1);
        step(1);
        stream(2, 0, 16'h1234);
        step(1);

        // cfg_start together with frame_done goes straight to LOAD.
        up_valid = 1'b1;
        step(1);
        up_valid = 1'b0;
        pulse_cfg(32'd500, 32'd2, 1'b1);
        begin_load(32'd500, 2);
        sample();
        chk("tc_busy", 64'(busy), 1);
        chk("tc_frame_en", 64'(frame_en), 0);
        chk("tc_s_ready", 64'(s_ready), 1);
        step(1);
        stream(2, 2, 16'h0);
        step(1);

        // 4: rejected requests.
        do_reset();
        pulse_cfg(32'd5, 32'd0, 1'b0);
        exp_errs++;
        sample();
        chk("t4_zero_err", 64'(err), 1);
        chk("t4_zero_frame_en", 64'(frame_en), 0);
        chk("t4_zero_busy", 64'(busy), 0);
        step(1);
        pulse_cfg(32'd200, 32'd3, 1'b0);
        begin_load(32'd200, 3);
        stream(1, 0, 16'hC001);
        pulse_cfg(32'd999, 32'd7, 1'b0);
        exp_errs++;
        sample();
        chk("t4_load_err", 64'(err), 1);
        chk("t4_load_busy", 64'(busy), 1);
        step(1);
        stream(2, 0, 16'hC002);
        sample();
        chk("t4_frame_en", 64'(frame_en), 1);
        step(1);

        // 5: address wrap.
        pulse_cfg(32'hFFFF_FFFE, 32'd3, 1'b0);
        begin_load(32'hFFFF_FFFE, 3);
        stream(3, 2, 16'h0);
        step(1);

        // 6: reset mid-load.
        pulse_cfg(32'h300, 32'd5, 1'b0);
        begin_load(32'h300, 5);
        stream(2, 0, 16'hD001);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        sample();
        chk("t6_s_ready", 64'(s_ready), 0);
        chk("t6_wr_en", 64'(weight_wr_en), 0);
        chk("t6_wr_addr", 64'(weight_wr_addr), 0);
        chk("t6_wr_data", 64'(weight_wr_data), 0);
        chk("t6_frame_en", 64'(frame_en), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_load_done", 64'(load_done), 0);
        step(1);
        frame_done = 1'b1;
        up_valid   = 1'b1;
        step(1);
        sample();
        chk("t6_fd_frame_en", 64'(frame_en), 0);
        chk("t6_conv_i_valid", 64'(conv_i_valid), 0);
        chk("t6_busy_after", 64'(busy), 0);
        step(1);
        frame_done = 1'b0;
        up_valid   = 1'b0;
        step(1);

        // Randomized loads, frames and deferred reloads.
        for (int it = 0; it < 12; it++) begin
            b = $urandom;
            n = $urandom_range(1, 6);
            pulse_cfg(b, 32'(n), 1'b0);
            begin_load(b, n);
            stream(n, 2, 16'h0);
            sample();
            chk("rnd_frame_en", 64'(frame_en), 1);
            chk("rnd_s_ready", 64'(s_ready), 0);
            step(1);
            up_valid = 1'b1;
            step(1);
            up_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                b = $urandom;
                n = $urandom_range(1, 5);
                pulse_cfg(b, 32'(n), 1'b0);
                step($urandom_range(0, 3));
                sample();
                chk("rnd_pend_frame_en", 64'(frame_en), 1);
                chk("rnd_pend_busy", 64'(busy), 1);
                step(1);
                pulse_fd();
                begin_load(b, n);
                stream(n, 2, 16'h0);
            end else begin
                step($urandom_range(0, 3));
                pulse_fd();
                sample();
                chk("rnd_ready_busy", 64'(busy), 0);
                step(1);
            end
        end

        step(3);
        chk("queue_drained", 64'(exp_q.size()), 0);
        chk("err_pulse_count", 64'(err_seen), 64'(exp_errs));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule

// File: doc/conv_weight_sched.md
Name: conv_weight_sched

Overview:
- Sequencer in front of one conv layer instance. It streams the layer's 16-bit weight/bias/coefficient words into the conv weight write port (`weight_wr_*`) from an upstream word stream.
- It gates the conv pixel input so a frame never starts while weights are incomplete.
- It defers any reload request until the in-flight frame finishes, signalled by the conv end-of-frame pulse.

Parameters:
- ADDR_WIDTH, 32, width of `weight_wr_addr`, `cfg_base_addr` and `cfg_num_words`.
- DATA_WIDTH, 16, weight word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low, sampled on rising `clk`.
- cfg_start  in  1  single-cycle pulse requesting a weight load.
- cfg_base_addr  in  ADDR_WIDTH  first weight address; sampled when a load is accepted.
- cfg_num_words  in  ADDR_WIDTH  number of words to load; sampled when a load is accepted.
- s_data  in  DATA_WIDTH  weight word stream data.
- s_valid  in  1  weight stream valid.
- s_ready  out  1  weight stream ready.
- weight_wr_data  out  DATA_WIDTH  to conv.
- weight_wr_addr  out  ADDR_WIDTH  to conv.
- weight_wr_en  out  1  to conv.
- up_valid  in  1  pixel valid from upstream FIFO side.
- conv_i_valid  out  1  gated pixel valid to conv: `up_valid & frame_en`.
- frame_done  in  1  conv end-of-frame pulse.
- frame_en  out  1  frames are permitted.
- busy  out  1  high in LOAD or PEND.
- load_done  out  1  one-cycle pulse on the last weight write.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset value of every output is 0; state resets to IDLE. Reset asserted mid-load abandons the load, leaves no pending request, and clears the loaded status.
- States:
  - IDLE: no weights loaded.
  - LOAD: streaming weights.
  - READY: weights valid, no frame in flight.
  - RUN: frame in flight.
  - PEND: reload requested during RUN.
- Transitions:
  - IDLE/READY + `cfg_start` with `cfg_num_words != 0` -> LOAD. Latch base into `addr_q`; latch count into `rem_q`.
  - IDLE/READY + `cfg_start` with `cfg_num_words == 0` -> stay, `err` pulse next cycle.
  - LOAD: `s_ready = 1`. Each cycle with `s_valid & s_ready`:
    - register data to `weight_wr_data` and `addr_q` to `weight_wr_addr`;
    - assert `weight_wr_en` the next cycle (latency 1);
    - `addr_q += 1` (mod 2^ADDR_WIDTH, wraps silently);
    - `rem_q -= 1`.
  - LOAD, accepting the word with `rem_q == 1` -> READY. `s_ready` drops the cycle after. `load_done` pulses together with that final `weight_wr_en`.
  - LOAD + `cfg_start` -> ignored, `err` pulse.
  - READY: `frame_en = 1`. The first cycle with `conv_i_valid = 1` -> RUN.
  - RUN: `frame_en = 1`. `frame_done` -> READY.
  - RUN + `cfg_start` -> PEND. The config is latched at that moment.
  - PEND: `frame_en` stays 1 until `frame_done`, then -> LOAD using the latched config. The frame is never cut.
  - PEND + a further `cfg_start` -> `err` pulse; the first request is kept.
  - `cfg_start` and `frame_done` in the same RUN cycle -> LOAD directly with the new config.
  - IDLE/LOAD: `frame_en = 0`, so `conv_i_valid = 0` (upstream FIFO holds data).
- `frame_done` outside RUN/PEND is ignored.
- Stall behaviour: while `s_valid = 0` in LOAD, no write occurs and the address holds; there is no timeout.
- `s_ready`, `frame_en`, `busy` and `weight_*` are driven from registers. `conv_i_valid` is combinational AND of `up_valid` and registered `frame_en`.

Decomposition:
- Shared package: state encoding localparams (IDLE=0, LOAD=1, READY=2, RUN=3, PEND=4) and the default DATA_WIDTH/ADDR_WIDTH constants.
- One natural sub-module: `weight_addr_gen`, which holds the base/remaining counter pair (load, decrement, last flag, wrap). The FSM and gating stay in the top module.

Test Plan:
1. Reset, then `cfg_start` with base=17176, num=4; stream 0xA001..0xA004 with `s_valid` held high -> `weight_wr_en` is high 4 cycles at addresses 17176..17179 with matching data; `load_done` pulses with the 4th write; `frame_en = 1` the cycle after; `s_ready = 0` after the 4th accept.
2. Repeat scenario 1 with `s_valid` toggling 1,0,1,0 -> writes occur only one cycle after each handshake; addresses stay contiguous; data order is preserved.
3. Loaded (READY), raise `up_valid` -> state RUN; `cfg_start` base=100 num=2 -> `frame_en` stays 1, `busy = 1`, no writes. Pulse `frame_done` -> `frame_en = 0` next cycle; writes go to addresses 100 and 101.
4. `cfg_start` with num=0 in IDLE -> `err` pulse; `frame_en` stays 0. `cfg_start` during LOAD -> `err` pulse; the load completes unaltered.
5. base=0xFFFFFFFE, num=3 -> write addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
6. Assert `rst_n = 0` after 2 of 5 words -> next cycle all outputs are 0 and the state is IDLE. A subsequent `frame_done` or `up_valid` produces no `frame_en` and no `conv_i_valid`.
